// File: rtl/cmult_arb.sv
// Round-robin arbiter sharing one pipelined complex multiplier among N_REQ requesters.
// Optional overflow latch (ovf_sticky/ovf_id) enabled by defining CMULT_ARB_OVF_LATCH_EN.
module cmult_arb #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned A_WIDTH = 16,
  parameter int unsigned B_WIDTH = 16,
  parameter int unsigned P_WIDTH = 16,
  parameter int unsigned LATENCY = 4,
  localparam int unsigned IDW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*A_WIDTH-1:0]   req_ar,
  input  logic [N_REQ*A_WIDTH-1:0]   req_ai,
  input  logic [N_REQ*B_WIDTH-1:0]   req_br,
  input  logic [N_REQ*B_WIDTH-1:0]   req_bi,
  output logic [A_WIDTH-1:0]         mul_ar,
  output logic [A_WIDTH-1:0]         mul_ai,
  output logic [B_WIDTH-1:0]         mul_br,
  output logic [B_WIDTH-1:0]         mul_bi,
  input  logic [P_WIDTH-1:0]         mul_pr,
  input  logic [P_WIDTH-1:0]         mul_pi,
  input  logic                       mul_err_ovf,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic [P_WIDTH-1:0]         rsp_pr,
  output logic [P_WIDTH-1:0]         rsp_pi,
  output logic                       rsp_ovf,
  input  logic                       flush,
  output logic                       flush_done
`ifdef CMULT_ARB_OVF_LATCH_EN
  ,
  output logic                       ovf_sticky,
  output logic [IDW-1:0]             ovf_id
`endif
);

  localparam int unsigned IFW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [IFW-1:0]       inflight_q, inflight_d;
  logic [LATENCY-1:0]   tag_v_q;
  logic [IDW-1:0]       tag_id_q [LATENCY];
  logic [A_WIDTH-1:0]   mul_ar_q, mul_ai_q;
  logic [B_WIDTH-1:0]   mul_br_q, mul_bi_q;

  logic                 grant_any;
  logic [IDW-1:0]       grant_idx;
  logic [IDW-1:0]       cand;
  int unsigned          cand_int;
  int unsigned          sel_a, sel_b;
  logic                 grant_en;
  logic                 issue;
  logic                 retire;
  logic                 drain_empty;
  logic                 rsp_hit;

  // Round-robin search starting at the pointer
  always_comb begin
    grant_any = 1'b0;
    grant_idx = ptr_q;
    cand_int  = 0;
    cand      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand_int = 32'(ptr_q) + i;
      if (cand_int >= N_REQ) cand_int = cand_int - N_REQ;
      cand = IDW'(cand_int);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign issue       = |req_ready;
  assign retire      = tag_v_q[LATENCY-1];
  assign inflight_d  = inflight_q + IFW'(issue) - IFW'(retire);
  assign drain_empty = (inflight_d == '0);
  assign sel_a       = 32'(grant_idx) * A_WIDTH;
  assign sel_b       = 32'(grant_idx) * B_WIDTH;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (flush) state_d = DRAIN;
               else if (|req_valid) state_d = RUN;
      RUN:     if (flush) state_d = DRAIN;
               else if (!issue && inflight_q == '0) state_d = IDLE;
      DRAIN:   if (drain_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: grant gating, flush completion, pointer update
  always_comb begin
    grant_en   = 1'b0;
    req_ready  = '0;
    flush_done = 1'b0;
    ptr_d      = ptr_q;
    grant_en   = !rst && !flush && (state_q != DRAIN);
    if (grant_en && grant_any) req_ready = N_REQ'(1) << grant_idx;
    flush_done = !rst && (state_q == DRAIN) && drain_empty;
    if (flush_done)  ptr_d = '0;
    else if (issue)  ptr_d = (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + IDW'(1);
  end

  // Tag pipeline, in-flight count, pointer and held multiplier operands
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      inflight_q <= '0;
      tag_v_q    <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) tag_id_q[i] <= '0;
      mul_ar_q   <= '0;
      mul_ai_q   <= '0;
      mul_br_q   <= '0;
      mul_bi_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      inflight_q  <= inflight_d;
      tag_v_q[0]  <= issue;
      tag_id_q[0] <= grant_idx;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        tag_v_q[i]  <= tag_v_q[i-1];
        tag_id_q[i] <= tag_id_q[i-1];
      end
      if (issue) begin
        mul_ar_q <= req_ar[sel_a +: A_WIDTH];
        mul_ai_q <= req_ai[sel_a +: A_WIDTH];
        mul_br_q <= req_br[sel_b +: B_WIDTH];
        mul_bi_q <= req_bi[sel_b +: B_WIDTH];
      end
    end
  end

  assign mul_ar = mul_ar_q;
  assign mul_ai = mul_ai_q;
  assign mul_br = mul_br_q;
  assign mul_bi = mul_bi_q;

  // Results pass straight through from the multiplier on the retire cycle
  assign rsp_hit   = !rst && retire;
  assign rsp_valid = rsp_hit ? (N_REQ'(1) << tag_id_q[LATENCY-1]) : '0;
  assign rsp_pr    = rsp_hit ? mul_pr : '0;
  assign rsp_pi    = rsp_hit ? mul_pi : '0;
  assign rsp_ovf   = rsp_hit && mul_err_ovf;

`ifdef CMULT_ARB_OVF_LATCH_EN
  logic           ovf_sticky_q;
  logic [IDW-1:0] ovf_id_q;

  // Capture the id of the first overflowing result until cleared
  always_ff @(posedge clk) begin
    if (rst || flush_done) begin
      ovf_sticky_q <= 1'b0;
      ovf_id_q     <= '0;
    end else if (rsp_ovf && !ovf_sticky_q) begin
      ovf_sticky_q <= 1'b1;
      ovf_id_q     <= tag_id_q[LATENCY-1];
    end
  end

  assign ovf_sticky = ovf_sticky_q;
  assign ovf_id     = ovf_id_q;
`endif

endmodule

// File: tb/tb_cmult_arb.sv
// Directed self-checking bench for cmult_arb with a Q2.14 complex multiplier model.
module tb_cmult_arb;

  localparam int unsigned N   = 4;
  localparam int unsigned AW  = 16;
  localparam int unsigned BW  = 16;
  localparam int unsigned PW  = 16;
  localparam int unsigned LAT = 4;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_ar, req_ai;
  logic [N*BW-1:0] req_br, req_bi;
  logic [AW-1:0]   mul_ar, mul_ai;
  logic [BW-1:0]   mul_br, mul_bi;
  logic [PW-1:0]   mul_pr, mul_pi;
  logic            mul_err_ovf;
  logic [N-1:0]    rsp_valid;
  logic [PW-1:0]   rsp_pr, rsp_pi;
  logic            rsp_ovf;
  logic            flush;
  logic            flush_done;
`ifdef CMULT_ARB_OVF_LATCH_EN
  logic            ovf_sticky;
  logic [1:0]      ovf_id;
`endif

  cmult_arb #(
    .N_REQ(N), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ar(req_ar), .req_ai(req_ai), .req_br(req_br), .req_bi(req_bi),
    .mul_ar(mul_ar), .mul_ai(mul_ai), .mul_br(mul_br), .mul_bi(mul_bi),
    .mul_pr(mul_pr), .mul_pi(mul_pi), .mul_err_ovf(mul_err_ovf),
    .rsp_valid(rsp_valid), .rsp_pr(rsp_pr), .rsp_pi(rsp_pi), .rsp_ovf(rsp_ovf),
    .flush(flush), .flush_done(flush_done)
`ifdef CMULT_ARB_OVF_LATCH_EN
    , .ovf_sticky(ovf_sticky), .ovf_id(ovf_id)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: operands appear the cycle after issue, product LAT cycles after issue
  logic [PW-1:0] pr_pipe [LAT-1];
  logic [PW-1:0] pi_pipe [LAT-1];
  logic [LAT-2:0] ovf_pipe;
  longint pr_full, pi_full;

  always @(posedge clk) begin
    pr_full = (longint'($signed(mul_ar)) * longint'($signed(mul_br))
             - longint'($signed(mul_ai)) * longint'($signed(mul_bi))) >>> 14;
    pi_full = (longint'($signed(mul_ar)) * longint'($signed(mul_bi))
             + longint'($signed(mul_ai)) * longint'($signed(mul_br))) >>> 14;
    pr_pipe[0]  <= PW'(pr_full);
    pi_pipe[0]  <= PW'(pi_full);
    ovf_pipe[0] <= (pr_full > 32767) || (pr_full < -32768) ||
                   (pi_full > 32767) || (pi_full < -32768);
    for (int i = 1; i < LAT - 1; i++) begin
      pr_pipe[i]  <= pr_pipe[i-1];
      pi_pipe[i]  <= pi_pipe[i-1];
      ovf_pipe[i] <= ovf_pipe[i-1];
    end
  end

  assign mul_pr      = pr_pipe[LAT-2];
  assign mul_pi      = pi_pipe[LAT-2];
  assign mul_err_ovf = ovf_pipe[LAT-2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int k, input logic [15:0] ar, input logic [15:0] ai,
                        input logic [15:0] br, input logic [15:0] bi);
    req_ar[k*AW +: AW] = ar;
    req_ai[k*AW +: AW] = ai;
    req_br[k*BW +: BW] = br;
    req_bi[k*BW +: BW] = bi;
  endtask

  // One cycle: drive at negedge, sample combinational outputs shortly after
  task automatic vec(input string tag, input logic r, input logic [3:0] v, input logic f,
                     input logic [3:0] e_rdy, input logic [3:0] e_rsp, input logic e_fd);
    @(negedge clk);
    rst       = r;
    req_valid = v;
    flush     = f;
    #1;
    check_eq({tag, " ready"}, 32'(req_ready), 32'(e_rdy));
    check_eq({tag, " rsp_valid"}, 32'(rsp_valid), 32'(e_rsp));
    check_eq({tag, " flush_done"}, 32'(flush_done), 32'(e_fd));
  endtask

  initial begin
    logic [3:0] e_rdy, e_rsp;
    int k;
    rst = 1'b1; req_valid = '0; flush = 1'b0;
    req_ar = '0; req_ai = '0; req_br = '0; req_bi = '0;

    // Reset: no grants even with valid requests, outputs cleared
    vec("rst0", 1'b1, 4'hF, 1'b0, 4'h0, 4'h0, 1'b0);
    vec("rst1", 1'b1, 4'hF, 1'b0, 4'h0, 4'h0, 1'b0);
    check_eq("rst mul_ar", 32'(mul_ar), 32'h0);
    check_eq("rst mul_bi", 32'(mul_bi), 32'h0);
    check_eq("rst rsp_pr", 32'(rsp_pr), 32'h0);
    check_eq("rst rsp_ovf", 32'(rsp_ovf), 32'h0);
    vec("idle0", 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);
    vec("idle1", 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);

    // All four requesters valid for 8 cycles: grants 0,1,2,3,0,1,2,3
    for (int i = 0; i < N; i++)
      set_op(i, 16'((i + 1) << 12), 16'((i + 1) << 8), 16'h4000, 16'h0000);
    for (int c = 0; c < 12; c++) begin
      e_rdy = (c < 8) ? 4'(1 << (c % 4)) : 4'h0;
      e_rsp = (c >= 4) ? 4'(1 << ((c - 4) % 4)) : 4'h0;
      vec($sformatf("rr c%0d", c), 1'b0, (c < 8) ? 4'hF : 4'h0, 1'b0, e_rdy, e_rsp, 1'b0);
      if (c >= 4) begin
        k = (c - 4) % 4;
        check_eq($sformatf("rr c%0d pr", c), 32'(rsp_pr), 32'((k + 1) << 12));
        check_eq($sformatf("rr c%0d pi", c), 32'(rsp_pi), 32'((k + 1) << 8));
        check_eq($sformatf("rr c%0d ovf", c), 32'(rsp_ovf), 32'h0);
      end
    end
    vec("gap0", 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);

    // Single requester 2: 1.0 * 1.0 = 1.0
    set_op(0, 16'h7777, 16'h1111, 16'h2222, 16'h3333);
    set_op(2, 16'h4000, 16'h0000, 16'h4000, 16'h0000);
    for (int c = 0; c < 6; c++) begin
      vec($sformatf("r2 c%0d", c), 1'b0, (c == 0) ? 4'b0100 : 4'h0, 1'b0,
          (c == 0) ? 4'b0100 : 4'h0, (c == 4) ? 4'b0100 : 4'h0, 1'b0);
      if (c == 4) begin
        check_eq("r2 pr", 32'(rsp_pr), 32'h4000);
        check_eq("r2 pi", 32'(rsp_pi), 32'h0);
      end
    end

    // Requester 1 then flush: drain, flush_done on retire, pointer back to 0
    vec("fl c0", 1'b0, 4'b0010, 1'b0, 4'b0010, 4'h0, 1'b0);
    vec("fl c1", 1'b0, 4'b1001, 1'b1, 4'h0, 4'h0, 1'b0);
    vec("fl c2", 1'b0, 4'b1001, 1'b0, 4'h0, 4'h0, 1'b0);
    vec("fl c3", 1'b0, 4'b1001, 1'b0, 4'h0, 4'h0, 1'b0);
    vec("fl c4", 1'b0, 4'b1001, 1'b0, 4'h0, 4'b0010, 1'b1);
    vec("fl c5", 1'b0, 4'b1001, 1'b0, 4'b0001, 4'h0, 1'b0);
    vec("fl c6", 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);
    vec("fl c7", 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);
    vec("fl c8", 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);
    vec("fl c9", 1'b0, 4'h0, 1'b0, 4'h0, 4'b0001, 1'b0);

    // Flush with nothing in flight: flush_done the next cycle, no grants meanwhile
    vec("fe c0", 1'b0, 4'hF, 1'b1, 4'h0, 4'h0, 1'b0);
    vec("fe c1", 1'b0, 4'hF, 1'b0, 4'h0, 4'h0, 1'b1);
    vec("fe c2", 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);

    // Reset two cycles after three issues discards them
    vec("rm c0", 1'b0, 4'hF, 1'b0, 4'b0001, 4'h0, 1'b0);
    vec("rm c1", 1'b0, 4'hF, 1'b0, 4'b0010, 4'h0, 1'b0);
    vec("rm c2", 1'b0, 4'hF, 1'b0, 4'b0100, 4'h0, 1'b0);
    vec("rm c3", 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);
    vec("rm c4", 1'b1, 4'hF, 1'b0, 4'h0, 4'h0, 1'b0);
    vec("rm c5", 1'b1, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);
    check_eq("rm mul_ar", 32'(mul_ar), 32'h0);
    check_eq("rm mul_br", 32'(mul_br), 32'h0);
    check_eq("rm rsp_pr", 32'(rsp_pr), 32'h0);
    for (int c = 6; c < 12; c++)
      vec($sformatf("rm c%0d", c), 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);

`ifdef CMULT_ARB_OVF_LATCH_EN
    // Overflow on requester 3 latched; later overflow from 0 does not replace it
    set_op(3, 16'h8000, 16'h0000, 16'h8000, 16'h0000);
    set_op(0, 16'h8000, 16'h0000, 16'h8000, 16'h0000);
    check_eq("ov init", 32'(ovf_sticky), 32'h0);
    for (int c = 0; c < 15; c++) begin
      e_rdy = (c == 0) ? 4'b1000 : (c == 6) ? 4'b0001 : 4'h0;
      e_rsp = (c == 4) ? 4'b1000 : (c == 10) ? 4'b0001 : 4'h0;
      vec($sformatf("ov c%0d", c), 1'b0, e_rdy, (c == 12), e_rdy, e_rsp, (c == 13));
      if (c == 4 || c == 10) check_eq($sformatf("ov c%0d rsp_ovf", c), 32'(rsp_ovf), 32'h1);
      if (c == 5 || c == 11 || c == 13) begin
        check_eq($sformatf("ov c%0d sticky", c), 32'(ovf_sticky), 32'h1);
        check_eq($sformatf("ov c%0d id", c), 32'(ovf_id), 32'h3);
      end
      if (c == 14) check_eq("ov cleared", 32'(ovf_sticky), 32'h0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cmult_arb.md
CMULT_ARB -- requirements
Module: cmult_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one cmult instance.
REQ-002 SHALL have parameter A_WIDTH, default 16, operand A component width.
REQ-003 SHALL have parameter B_WIDTH, default 16, operand B component width.
REQ-004 SHALL have parameter P_WIDTH, default 16, product component width.
REQ-005 SHALL have parameter LATENCY, default 4, cycles from operand issue to product on mul_pr/mul_pi.
REQ-006 SHALL have port clk  in  1  sole clock; rising edge.
REQ-007 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-008 SHALL have port req_valid  in  N_REQ  per-requester operand valid.
REQ-009 SHALL have port req_ready  out  N_REQ  per-requester grant; one-hot or zero.
REQ-010 SHALL have ports req_ar, req_ai  in  N_REQ*A_WIDTH  packed operand A; requester k at slice k.
REQ-011 SHALL have ports req_br, req_bi  in  N_REQ*B_WIDTH  packed operand B.
REQ-012 SHALL have ports mul_ar, mul_ai  out  A_WIDTH, and mul_br, mul_bi  out  B_WIDTH  to multiplier.
REQ-013 SHALL have ports mul_pr, mul_pi  in  P_WIDTH, and mul_err_ovf  in  1  from multiplier.
REQ-014 SHALL have ports rsp_valid  out  N_REQ  one-hot result strobe; rsp_pr, rsp_pi  out  P_WIDTH; rsp_ovf  out  1.
REQ-015 SHALL have ports flush  in  1  drain request; flush_done  out  1  single-cycle pulse.

Function
REQ-016 SHALL transfer an operand on a cycle when req_valid[k] and req_ready[k] are both high.
REQ-017 SHALL compute req_ready combinationally from req_valid, the round-robin pointer, and state; at most one bit set.
REQ-018 SHALL grant round-robin: search starts at pointer; after a grant to k, pointer becomes (k+1) mod N_REQ; pointer unchanged when no grant.
REQ-019 SHALL drive mul_* from the granted slice; hold last issued operands when no grant.
REQ-020 SHALL track each issue with a LATENCY-deep pipeline of {valid, id}; no result backpressure.
REQ-021 SHALL assert rsp_valid[id] exactly LATENCY cycles after the transfer, with rsp_pr/rsp_pi/rsp_ovf passed through from mul_pr/mul_pi/mul_err_ovf that cycle.
REQ-022 SHALL sustain one issue per cycle; back-to-back grants to different requesters permitted.
REQ-023 SHALL implement states IDLE, RUN, DRAIN.
REQ-024 IDLE->RUN when any req_valid is high and flush is low; grant allowed in that same cycle.
REQ-025 RUN->IDLE when no issue this cycle and no operation in flight.
REQ-026 IDLE/RUN->DRAIN on flush high; no grant in the cycle flush is high or while in DRAIN.
REQ-027 DRAIN->IDLE when in-flight count reaches zero; flush_done pulses that cycle, pointer resets to 0.
REQ-028 If DRAIN is entered with nothing in flight, flush_done SHALL pulse on the next cycle.
REQ-029 SHALL keep an in-flight counter 0..LATENCY; simultaneous issue and retire leave it unchanged.

Reset
REQ-030 rst high SHALL set state IDLE, pointer 0, tag pipeline empty, in-flight 0, mul_* 0, rsp_valid 0, rsp_pr/rsp_pi/rsp_ovf 0, flush_done 0, req_ready 0.
REQ-031 rst mid-operation SHALL discard all in-flight tags; no rsp_valid for operations issued before reset.

Configuration
REQ-032 Macro CMULT_ARB_OVF_LATCH_EN defined: SHALL add outputs ovf_sticky (1) and ovf_id (clog2(N_REQ)), capturing the id of the first result with rsp_ovf high; cleared only by rst or flush_done.
REQ-033 Macro not defined: SHALL omit ovf_sticky/ovf_id ports and logic; all other behaviour identical.

Verification
REQ-034 All 4 req_valid high continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3; rsp_valid same order, each 4 cycles later.
REQ-035 Only requester 2 valid, ar=0x4000, br=0x4000, ai=bi=0 -> rsp_valid[2] after 4 cycles, rsp_pr=0x4000, rsp_pi=0.
REQ-036 Requester 1 single transfer, then flush the next cycle -> no new grants, rsp_valid[1] delivered, flush_done pulses on that retire cycle, pointer back to 0.
REQ-037 Reset asserted 2 cycles after 3 issues -> no rsp_valid afterwards; all outputs at reset values.
REQ-038 With CMULT_ARB_OVF_LATCH_EN, mul_err_ovf high on requester 3's result -> ovf_sticky=1, ovf_id=3, held until flush_done.
